p405s_srm_rot_arb: RTL and testbench

- Arbitrates and sequences the shared 32-bit barrel left rotator between two requesters:
  - Requester 0: EXE integer shift/rotate ops.
  - Requester 1: load/store data alignment.
- Converts each op (rotate left, shift left logical, shift right logical) into a rotate amount plus a bit mask.
- Drives the external rotator through a registered issue stage, masks its output, and returns the result with a requester tag over a valid/ready handshake.

---
 rtl/p405s_srm_rot_arb.sv | 231 +++++++++++++++++++++++
 tb/tb_p405s_srm_rot_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_srm_rot_arb.sv
// ----------------------------------------------------------------------------
// p405s_srm_rot_arb
//   Shares one external 32-bit barrel left rotator between two requesters:
//     requester 0 - EXE integer shift/rotate ops
//     requester 1 - load/store data alignment
//   Each accepted op is turned into a left-rotate amount plus a bit mask in an
//   issue register (S1) that drives the rotator. The rotator output is masked
//   and captured in a result register (S2) and returned with a requester tag
//   over a valid/ready handshake.
//
//   Bit numbering: the architectural view numbers bit 0 as the MSB. Vectors
//   here are declared [31:0], so architectural bit k is vector bit 31-k. A
//   left rotate moves bits towards the MSB in both views.
// ----------------------------------------------------------------------------
module p405s_srm_rot_arb #(
  // Cycles requester 1 may be refused while requesting before it wins (1..15)
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CB,
  input  logic        reset,
  // Requester 0: EXE shift/rotate
  input  logic        req0Val,
  output logic        req0Rdy,
  input  logic [31:0] req0Data,
  input  logic [4:0]  req0Amt,
  input  logic [1:0]  req0Op,
  // Requester 1: load/store alignment
  input  logic        req1Val,
  output logic        req1Rdy,
  input  logic [31:0] req1Data,
  input  logic [4:0]  req1Amt,
  input  logic [1:0]  req1Op,
  // External rotator
  output logic [31:0] rotData_NEG,
  output logic [4:0]  rotAmt,
  input  logic [31:0] rotResult,
  // Result handshake
  output logic        resVal,
  input  logic        resRdy,
  output logic [31:0] resData,
  output logic        resTag
);

  // Op encodings; 2'b11 is reserved and behaves as a rotate
  localparam logic [1:0] OP_ROTL = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // --------------------------------------------------------------------------
  // Op conversion helpers
  // --------------------------------------------------------------------------

  // Left-rotate amount: a right shift by n is a left rotate by 32-n, and the
  // 5-bit wrap makes n = 0 come out as 0.
  function automatic logic [4:0] rot_amount(input logic [1:0] op,
                                            input logic [4:0] n);
    case (op)
      OP_SRL:  return 5'd0 - n;
      default: return n;
    endcase
  endfunction

  // Mask that clears the bits a rotate wrapped around. For sll the n LSBs are
  // cleared, for srl the n MSBs; n = 0 leaves the mask all ones.
  function automatic logic [31:0] shift_mask(input logic [1:0] op,
                                             input logic [4:0] n);
    case (op)
      OP_SLL:  return 32'hFFFF_FFFF << n;
      OP_SRL:  return 32'hFFFF_FFFF >> n;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic        s1_val_q,       s1_val_d;
  logic        s1_tag_q,       s1_tag_d;
  logic [31:0] s1_mask_q,      s1_mask_d;
  logic [4:0]  rot_amt_q,      rot_amt_d;
  logic [31:0] rot_data_neg_q, rot_data_neg_d;

  logic        res_val_q,      res_val_d;
  logic [31:0] res_data_q,     res_data_d;
  logic        res_tag_q,      res_tag_d;

  logic [3:0]  starve_cnt_q,   starve_cnt_d;

  // --------------------------------------------------------------------------
  // Flow control and arbitration
  // --------------------------------------------------------------------------
  logic        can_adv_s2;
  logic        can_load_s1;
  logic        starve_hit;
  logic        gnt0;
  logic        gnt1;
  logic        accept;

  logic [31:0] sel_data;
  logic [4:0]  sel_amt;
  logic [1:0]  sel_op;

  // S2 may take a new value when empty or being drained this cycle; S1 may
  // take a new op when empty or when its op moves on into S2. An empty S1
  // can therefore still fill while S2 is stalled; it then holds.
  assign can_adv_s2  = ~res_val_q | resRdy;
  assign can_load_s1 = ~s1_val_q | can_adv_s2;

  // Requester 0 wins by default; requester 1 wins alone or once it has been
  // refused STARVE_LIMIT consecutive requesting cycles.
  assign starve_hit = (starve_cnt_q == STARVE_MAX);
  assign gnt1       = req1Val & (~req0Val | starve_hit);
  assign gnt0       = req0Val & ~gnt1;

  // Ready is held low while reset is asserted so nothing is handed off into
  // a pipeline that is being cleared.
  assign req0Rdy = ~reset & can_load_s1 & gnt0;
  assign req1Rdy = ~reset & can_load_s1 & gnt1;
  assign accept  = req0Rdy | req1Rdy;

  // Operand mux for the winning requester
  assign sel_data = gnt1 ? req1Data : req0Data;
  assign sel_amt  = gnt1 ? req1Amt  : req0Amt;
  assign sel_op   = gnt1 ? req1Op   : req0Op;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // S1 issue stage: load a new op, empty out, or hold while blocked
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise the tool infers a latch to hold the old value.
    s1_val_d       = s1_val_q;
    s1_tag_d       = s1_tag_q;
    s1_mask_d      = s1_mask_q;
    rot_amt_d      = rot_amt_q;
    rot_data_neg_d = rot_data_neg_q;
    if (can_load_s1) begin
      s1_val_d = accept;
      // Operand, amount and mask keep their last value while S1 is empty
      if (accept) begin
        s1_tag_d       = gnt1;
        s1_mask_d      = shift_mask(sel_op, sel_amt);
        rot_amt_d      = rot_amount(sel_op, sel_amt);
        rot_data_neg_d = ~sel_data;
      end
    end
  end

  // S2 result stage: capture masked rotator output when S1 advances
  always_comb begin
    res_val_d  = res_val_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    if (can_adv_s2) begin
      res_val_d = s1_val_q;
      if (s1_val_q) begin
        res_data_d = rotResult & s1_mask_q;
        res_tag_d  = s1_tag_q;
      end
    end
  end

  // Starvation counter: counts refused requesting cycles of requester 1
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1Val || req1Rdy) begin
      starve_cnt_d = 4'd0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // S1 issue register; the operand resets to all ones (inverted zero)
  always_ff @(posedge CB or posedge reset) begin
    if (reset) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples the pre-edge values and ordering between blocks is moot.
      s1_val_q       <= 1'b0;
      s1_tag_q       <= 1'b0;
      s1_mask_q      <= 32'hFFFF_FFFF;
      rot_amt_q      <= 5'd0;
      rot_data_neg_q <= 32'hFFFF_FFFF;
    end else begin
      s1_val_q       <= s1_val_d;
      s1_tag_q       <= s1_tag_d;
      s1_mask_q      <= s1_mask_d;
      rot_amt_q      <= rot_amt_d;
      rot_data_neg_q <= rot_data_neg_d;
    end
  end

  // S2 result register
  always_ff @(posedge CB or posedge reset) begin
    if (reset) begin
      res_val_q  <= 1'b0;
      res_data_q <= 32'h0;
      res_tag_q  <= 1'b0;
    end else begin
      res_val_q  <= res_val_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
    end
  end

  // Starvation counter register
  always_ff @(posedge CB or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rotData_NEG = rot_data_neg_q;
  assign rotAmt      = rot_amt_q;
  assign resVal      = res_val_q;
  assign resData     = res_data_q;
  assign resTag      = res_tag_q;

endmodule

// File: tb/tb_p405s_srm_rot_arb.sv
// ----------------------------------------------------------------------------
// tb_p405s_srm_rot_arb
//   Bench for the rotator arbiter. Models the external rotator, applies a
//   table of single ops, hand sequences for backpressure, starvation and
//   reset, then random traffic against a behavioural reference model.
// ----------------------------------------------------------------------------
module tb_p405s_srm_rot_arb;

  localparam int LIMIT = 4;

  logic        CB = 1'b0;
  logic        reset;
  logic        req0Val, req0Rdy;
  logic [31:0] req0Data;
  logic [4:0]  req0Amt;
  logic [1:0]  req0Op;
  logic        req1Val, req1Rdy;
  logic [31:0] req1Data;
  logic [4:0]  req1Amt;
  logic [1:0]  req1Op;
  logic [31:0] rotData_NEG;
  logic [4:0]  rotAmt;
  logic [31:0] rotResult;
  logic        resVal;
  logic        resRdy;
  logic [31:0] resData;
  logic        resTag;

  int total = 0;
  int bad   = 0;

  p405s_srm_rot_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .CB         (CB),
    .reset      (reset),
    .req0Val    (req0Val),
    .req0Rdy    (req0Rdy),
    .req0Data   (req0Data),
    .req0Amt    (req0Amt),
    .req0Op     (req0Op),
    .req1Val    (req1Val),
    .req1Rdy    (req1Rdy),
    .req1Data   (req1Data),
    .req1Amt    (req1Amt),
    .req1Op     (req1Op),
    .rotData_NEG(rotData_NEG),
    .rotAmt     (rotAmt),
    .rotResult  (rotResult),
    .resVal     (resVal),
    .resRdy     (resRdy),
    .resData    (resData),
    .resTag     (resTag)
  );

  always #5 CB = ~CB;

  // Left rotate towards the MSB
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  // External rotator: true-polarity output from the inverted operand
  assign rotResult = rotl(~rotData_NEG, rotAmt);

  // Reference result straight from the op definitions
  function automatic logic [31:0] ref_result(input logic [31:0] d,
                                             input logic [4:0] n,
                                             input logic [1:0] op);
    case (op)
      2'b01:   return d << n;
      2'b10:   return d >> n;
      default: return rotl(d, n);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic idle();
    req0Val = 1'b0; req0Data = '0; req0Amt = '0; req0Op = '0;
    req1Val = 1'b0; req1Data = '0; req1Amt = '0; req1Op = '0;
  endtask

  task automatic drive(input bit sel, input logic [31:0] d,
                       input logic [4:0] n, input logic [1:0] op);
    idle();
    if (sel) begin
      req1Val = 1'b1; req1Data = d; req1Amt = n; req1Op = op;
    end else begin
      req0Val = 1'b1; req0Data = d; req0Amt = n; req0Op = op;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    resRdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Single-op vectors: inputs plus expected rotate amount and result
  typedef struct {
    bit          sel;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [1:0]  op;
    logic [4:0]  exp_amt;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  // Reference model state for the random phase
  bit          m_s1v, m_s1t, m_s2v, m_s2t;
  logic [31:0] m_s1d, m_s2d;
  int          m_cnt;

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0001, 5'd1,  2'b00, 5'd1,  32'h0000_0003};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 5'd4,  2'b01, 5'd4,  32'hFFFF_FFF0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 5'd4,  2'b10, 5'd28, 32'h0FFF_FFFF};
    vecs[3] = '{1'b1, 32'h1234_5678, 5'd0,  2'b10, 5'd0,  32'h1234_5678};
    vecs[4] = '{1'b0, 32'h1234_5678, 5'd0,  2'b01, 5'd0,  32'h1234_5678};
    vecs[5] = '{1'b0, 32'h8000_0001, 5'd31, 2'b00, 5'd31, 32'hC000_0000};
    vecs[6] = '{1'b1, 32'h0000_000F, 5'd8,  2'b11, 5'd8,  32'h0000_0F00};
    vecs[7] = '{1'b0, 32'h8000_0000, 5'd31, 2'b10, 5'd1,  32'h0000_0001};
    vecs[8] = '{1'b1, 32'h0000_0001, 5'd31, 2'b01, 5'd31, 32'h8000_0000};

    // ---------------- reset state (requests held high during reset) -------
    reset  = 1'b1;
    resRdy = 1'b1;
    idle();
    req0Val = 1'b1;
    req1Val = 1'b1;
    tick();
    check("rst_resVal",   32'(resVal),   32'h0);
    check("rst_resData",  resData,       32'h0);
    check("rst_resTag",   32'(resTag),   32'h0);
    check("rst_rotNeg",   rotData_NEG,   32'hFFFF_FFFF);
    check("rst_rotAmt",   32'(rotAmt),   32'h0);
    check("rst_rdy0",     32'(req0Rdy),  32'h0);
    check("rst_rdy1",     32'(req1Rdy),  32'h0);
    reset = 1'b0;
    idle();
    tick();

    // ---------------- table of single ops ---------------------------------
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].data, vecs[i].amt, vecs[i].op);
      #1;
      check($sformatf("v%0d_rdy", i),
            32'(vecs[i].sel ? req1Rdy : req0Rdy), 32'h1);
      check($sformatf("v%0d_rdy_other", i),
            32'(vecs[i].sel ? req0Rdy : req1Rdy), 32'h0);
      tick();
      idle();
      check($sformatf("v%0d_s1_resVal", i), 32'(resVal), 32'h0);
      check($sformatf("v%0d_rotAmt", i), 32'(rotAmt), 32'(vecs[i].exp_amt));
      check($sformatf("v%0d_rotNeg", i), rotData_NEG, ~vecs[i].data);
      tick();
      check($sformatf("v%0d_resVal", i), 32'(resVal), 32'h1);
      check($sformatf("v%0d_resData", i), resData, vecs[i].exp_data);
      check($sformatf("v%0d_resTag", i), 32'(resTag), 32'(vecs[i].sel));
      tick();
      check($sformatf("v%0d_drained", i), 32'(resVal), 32'h0);
      // Operand holds its last value while S1 is empty
      check($sformatf("v%0d_rotNeg_hold", i), rotData_NEG, ~vecs[i].data);
    end

    // ---------------- back-to-back then backpressure ----------------------
    begin
      logic [31:0] d[4];
      logic [31:0] e[4];
      d[0] = 32'h0000_1111; d[1] = 32'h0000_2222;
      d[2] = 32'h0000_3333; d[3] = 32'h0000_4444;
      foreach (d[k]) e[k] = ref_result(d[k], 5'(k + 1), 2'b00);
      resRdy = 1'b1;
      drive(1'b0, d[0], 5'd1, 2'b00); #1;
      check("b2b_rdyA", 32'(req0Rdy), 32'h1);
      tick();
      drive(1'b0, d[1], 5'd2, 2'b00); #1;
      check("b2b_rdyB", 32'(req0Rdy), 32'h1);
      check("b2b_noresB", 32'(resVal), 32'h0);
      tick();
      drive(1'b0, d[2], 5'd3, 2'b00); #1;
      check("b2b_rdyC", 32'(req0Rdy), 32'h1);
      check("b2b_resA", resData, e[0]);
      check("b2b_valA", 32'(resVal), 32'h1);
      tick();
      resRdy = 1'b0;
      drive(1'b0, d[3], 5'd4, 2'b00);
      for (int s = 0; s < 3; s++) begin
        #1;
        check($sformatf("stall%0d_val", s), 32'(resVal), 32'h1);
        check($sformatf("stall%0d_data", s), resData, e[1]);
        check($sformatf("stall%0d_tag", s), 32'(resTag), 32'h0);
        check($sformatf("stall%0d_rdy", s), 32'(req0Rdy), 32'h0);
        check($sformatf("stall%0d_rotAmt", s), 32'(rotAmt), 32'd3);
        tick();
      end
      resRdy = 1'b1; #1;
      check("rel_rdyD", 32'(req0Rdy), 32'h1);
      check("rel_resB", resData, e[1]);
      tick();
      idle();
      check("rel_resC", resData, e[2]);
      check("rel_valC", 32'(resVal), 32'h1);
      tick();
      check("rel_resD", resData, e[3]);
      check("rel_valD", 32'(resVal), 32'h1);
      tick();
      check("rel_empty", 32'(resVal), 32'h0);
    end

    // ---------------- starvation ------------------------------------------
    do_reset();
    req0Val = 1'b1; req1Val = 1'b1;
    for (int c = 0; c < 15; c++) begin
      req0Data = 32'(c); req1Data = 32'(c + 100);
      #1;
      check($sformatf("stv%0d_rdy0", c), 32'(req0Rdy), 32'((c % 5) != 4));
      check($sformatf("stv%0d_rdy1", c), 32'(req1Rdy), 32'((c % 5) == 4));
      tick();
    end
    // Counter clears when req1Val drops
    do_reset();
    req0Val = 1'b1; req1Val = 1'b1;
    tick(); tick();
    req1Val = 1'b0;
    tick();
    req1Val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("clr%0d_rdy1", c), 32'(req1Rdy), 32'(c == 4));
      tick();
    end
    idle();
    tick(); tick();

    // ---------------- async reset mid-flight ------------------------------
    do_reset();
    resRdy = 1'b0;
    drive(1'b0, 32'hAAAA_0000, 5'd3, 2'b00);
    tick();
    drive(1'b1, 32'h5555_0000, 5'd5, 2'b01);
    tick();
    idle();
    check("mf_full", 32'(resVal), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("mf_async_val", 32'(resVal), 32'h0);
    check("mf_async_data", resData, 32'h0);
    tick();
    reset  = 1'b0;
    resRdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("mf_noresult%0d", c), 32'(resVal), 32'h0);
    end
    drive(1'b1, 32'h0000_00F0, 5'd4, 2'b10); #1;
    check("mf_next_rdy", 32'(req1Rdy), 32'h1);
    tick();
    idle();
    check("mf_next_lat1", 32'(resVal), 32'h0);
    tick();
    check("mf_next_val", 32'(resVal), 32'h1);
    check("mf_next_data", resData, 32'h0000_000F);
    check("mf_next_tag", 32'(resTag), 32'h1);
    tick();

    // ---------------- random traffic vs reference model -------------------
    do_reset();
    m_s1v = 0; m_s2v = 0; m_s1t = 0; m_s2t = 0;
    m_s1d = '0; m_s2d = '0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      bit can_adv, can_load, w1, w0, r0, r1;
      req0Val  = ($urandom_range(0, 9) < 8);
      req1Val  = ($urandom_range(0, 9) < 6);
      req0Data = $urandom; req0Amt = 5'($urandom); req0Op = 2'($urandom);
      req1Data = $urandom; req1Amt = 5'($urandom); req1Op = 2'($urandom);
      resRdy   = ($urandom_range(0, 9) < 7);
      #1;
      can_adv  = !m_s2v || resRdy;
      can_load = !m_s1v || can_adv;
      w1 = req1Val && (!req0Val || m_cnt == LIMIT);
      w0 = req0Val && !w1;
      r0 = can_load && w0;
      r1 = can_load && w1;
      check("rnd_rdy0", 32'(req0Rdy), 32'(r0));
      check("rnd_rdy1", 32'(req1Rdy), 32'(r1));
      check("rnd_resVal", 32'(resVal), 32'(m_s2v));
      if (m_s2v) begin
        check("rnd_resData", resData, m_s2d);
        check("rnd_resTag", 32'(resTag), 32'(m_s2t));
      end
      // Advance the model across the coming edge
      if (can_adv) begin
        m_s2v = m_s1v;
        if (m_s1v) begin m_s2d = m_s1d; m_s2t = m_s1t; end
      end
      if (can_load) begin
        m_s1v = r0 || r1;
        if (r1)      begin m_s1d = ref_result(req1Data, req1Amt, req1Op); m_s1t = 1; end
        else if (r0) begin m_s1d = ref_result(req0Data, req0Amt, req0Op); m_s1t = 0; end
      end
      if (!req1Val || r1) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      tick();
    end

    idle();
    resRdy = 1'b1;
    tick(); tick(); tick();
    check("final_empty", 32'(resVal), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
